// File: rtl/screen_fill_requester_pkg.sv
// Shared encodings for the screen fill requester: FSM states and per-pixel colour modes.
package screen_fill_requester_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_OVR = 2'd0;
  localparam logic [1:0] MODE_XOR = 2'd1;
  localparam logic [1:0] MODE_OR  = 2'd2;

endpackage

// File: rtl/screen_fill_requester_cmd_fifo.sv
// Synchronous command FIFO; a push while full is refused even if a pop happens that cycle.
module screen_fill_requester_cmd_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/screen_fill_requester.sv
// Queues rectangle-fill commands and plays them one at a time into screen_writer,
// mixing the command colour with the existing pixel colour and aborting hung fills.
module screen_fill_requester
  import screen_fill_requester_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned COLOUR_WIDTH = 3,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned TIMEOUT      = 65536
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [WIDTH-1:0]        cmd_x_min,
  input  logic [WIDTH-1:0]        cmd_y_min,
  input  logic [WIDTH-1:0]        cmd_x_range,
  input  logic [WIDTH-1:0]        cmd_y_range,
  input  logic [COLOUR_WIDTH-1:0] cmd_colour,
  input  logic [1:0]              cmd_mode,
  output logic                    screen_start,
  output logic [WIDTH-1:0]        screen_x_min,
  output logic [WIDTH-1:0]        screen_y_min,
  output logic [WIDTH-1:0]        screen_x_range,
  output logic [WIDTH-1:0]        screen_y_range,
  output logic [COLOUR_WIDTH-1:0] new_screen_colour,
  input  logic [WIDTH-1:0]        screen_x,
  input  logic [WIDTH-1:0]        screen_y,
  input  logic [COLOUR_WIDTH-1:0] old_screen_colour,
  input  logic                    screen_done,
  output logic                    busy,
  output logic [15:0]             fills_done,
  output logic                    timeout_err
);

  localparam int unsigned CMD_W = 4 * WIDTH + COLOUR_WIDTH + 2;
  localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t                  state;
  state_t                  state_next;
  logic [CMD_W-1:0]        fifo_head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_pop;
  logic                    latch;
  logic                    complete;
  logic                    abort;
  logic                    fill_ok;
  logic [WD_W-1:0]         wd_cnt;
  logic [COLOUR_WIDTH-1:0] act_colour;
  logic [1:0]              act_mode;
  logic [WIDTH-1:0]        h_x_min;
  logic [WIDTH-1:0]        h_y_min;
  logic [WIDTH-1:0]        h_x_range;
  logic [WIDTH-1:0]        h_y_range;
  logic [COLOUR_WIDTH-1:0] h_colour;
  logic [1:0]              h_mode;
  logic                    unused_pixel;

  // Pixel coordinates are part of the interface but not needed for colour mixing.
  assign unused_pixel = ^{screen_x, screen_y};

  screen_fill_requester_cmd_fifo #(
    .DATA_W (CMD_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (cmd_valid),
    .push_data ({cmd_x_min, cmd_y_min, cmd_x_range, cmd_y_range, cmd_colour, cmd_mode}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign {h_x_min, h_y_min, h_x_range, h_y_range, h_colour, h_mode} = fifo_head;
  assign cmd_ready = !fifo_full;
  assign busy      = !fifo_empty || (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    latch      = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          latch      = 1'b1;
          state_next = S_START;
        end
      end
      S_START: begin
        fifo_pop   = 1'b1;
        state_next = S_BUSY;
      end
      S_BUSY: begin
        if (screen_done) begin
          complete   = 1'b1;
          state_next = S_DONE;
        end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
          abort      = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Active command, start pulse, watchdog and status counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      screen_start   <= 1'b0;
      screen_x_min   <= '0;
      screen_y_min   <= '0;
      screen_x_range <= '0;
      screen_y_range <= '0;
      act_colour     <= '0;
      act_mode       <= '0;
      wd_cnt         <= '0;
      fill_ok        <= 1'b0;
      fills_done     <= '0;
      timeout_err    <= 1'b0;
    end else begin
      screen_start <= latch;
      if (latch) begin
        screen_x_min   <= h_x_min;
        screen_y_min   <= h_y_min;
        screen_x_range <= h_x_range;
        screen_y_range <= h_y_range;
        act_colour     <= h_colour;
        act_mode       <= h_mode;
      end
      if (state == S_START)     wd_cnt <= '0;
      else if (state == S_BUSY) wd_cnt <= wd_cnt + WD_W'(1);
      if (state == S_BUSY) fill_ok <= complete;
      if (state == S_DONE && fill_ok) fills_done <= fills_done + 16'd1;
      if (abort) timeout_err <= 1'b1;
    end
  end

  always_comb begin
    new_screen_colour = '0;
    if (state != S_IDLE) begin
      case (act_mode)
        MODE_XOR: new_screen_colour = act_colour ^ old_screen_colour;
        MODE_OR:  new_screen_colour = act_colour | old_screen_colour;
        default:  new_screen_colour = act_colour;
      endcase
    end
  end

endmodule

// File: tb/tb_screen_fill_requester.sv
// Randomized bench for screen_fill_requester against a fill-lifecycle reference model.
module tb_screen_fill_requester;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 16;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] xr;
    logic [7:0] yr;
    logic [2:0] col;
    logic [1:0] mode;
  } cmd_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_x_min = '0, cmd_y_min = '0, cmd_x_range = '0, cmd_y_range = '0;
  logic [2:0] cmd_colour = '0;
  logic [1:0] cmd_mode = '0;
  logic       screen_start;
  logic [7:0] screen_x_min, screen_y_min, screen_x_range, screen_y_range;
  logic [2:0] new_screen_colour;
  logic [7:0] screen_x = '0, screen_y = '0;
  logic [2:0] old_screen_colour = '0;
  logic       screen_done = 1'b0;
  logic       busy;
  logic [15:0] fills_done;
  logic       timeout_err;

  int errors = 0;
  int checks = 0;

  // Reference model: queue contents plus the lifecycle of the current fill.
  cmd_t        m_q[$];
  cmd_t        m_act;
  bit          m_have;
  bit          m_fin;
  bit          m_ok;
  int          m_age;
  logic [15:0] m_fills;
  bit          m_terr;
  bit          model_ok = 1'b0;

  screen_fill_requester #(
    .WIDTH(8), .COLOUR_WIDTH(3), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x_min(cmd_x_min), .cmd_y_min(cmd_y_min),
    .cmd_x_range(cmd_x_range), .cmd_y_range(cmd_y_range),
    .cmd_colour(cmd_colour), .cmd_mode(cmd_mode),
    .screen_start(screen_start),
    .screen_x_min(screen_x_min), .screen_y_min(screen_y_min),
    .screen_x_range(screen_x_range), .screen_y_range(screen_y_range),
    .new_screen_colour(new_screen_colour),
    .screen_x(screen_x), .screen_y(screen_y),
    .old_screen_colour(old_screen_colour), .screen_done(screen_done),
    .busy(busy), .fills_done(fills_done), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] mix(input logic [2:0] c, input logic [1:0] m, input logic [2:0] o);
    case (m)
      2'd1:    return c ^ o;
      2'd2:    return c | o;
      default: return c;
    endcase
  endfunction

  function automatic cmd_t rnd_cmd();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return cmd_t'(r[$bits(cmd_t)-1:0]);
  endfunction

  task automatic compare();
    check("cmd_ready", 32'(cmd_ready), 32'(m_q.size() < DEPTH));
    check("busy", 32'(busy), 32'(m_q.size() != 0 || m_have));
    check("screen_start", 32'(screen_start), 32'(m_have && !m_fin && m_age == 0));
    check("x_min", 32'(screen_x_min), 32'(m_act.x));
    check("y_min", 32'(screen_y_min), 32'(m_act.y));
    check("x_range", 32'(screen_x_range), 32'(m_act.xr));
    check("y_range", 32'(screen_y_range), 32'(m_act.yr));
    check("new_colour", 32'(new_screen_colour),
          32'(m_have ? mix(m_act.col, m_act.mode, old_screen_colour) : 3'd0));
    check("fills_done", 32'(fills_done), 32'(m_fills));
    check("timeout_err", 32'(timeout_err), 32'(m_terr));
  endtask

  // Advance the model across one clock edge using the inputs held during the cycle.
  task automatic model_update();
    bit push;
    bit pop;
    if (reset) begin
      m_q.delete();
      m_act = '0; m_have = 0; m_fin = 0; m_ok = 0; m_age = 0;
      m_fills = '0; m_terr = 0;
      model_ok = 1'b1;
      return;
    end
    push = cmd_valid && (m_q.size() < DEPTH);
    pop  = m_have && !m_fin && m_age == 0;
    if (!m_have) begin
      if (m_q.size() > 0) begin
        m_have = 1; m_fin = 0; m_ok = 0; m_age = 0; m_act = m_q[0];
      end
    end else if (m_fin) begin
      if (m_ok) m_fills = m_fills + 16'd1;
      m_have = 0;
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (screen_done) begin
      m_fin = 1; m_ok = 1;
    end else if (m_age == TMO) begin
      m_fin = 1; m_ok = 0; m_terr = 1;
    end else begin
      m_age++;
    end
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back(cmd_t'({cmd_x_min, cmd_y_min, cmd_x_range, cmd_y_range, cmd_colour, cmd_mode}));
  endtask

  task automatic step(input bit rst, input bit v, input cmd_t c, input bit done, input logic [2:0] old);
    @(negedge clock);
    reset = rst;
    cmd_valid = v;
    {cmd_x_min, cmd_y_min, cmd_x_range, cmd_y_range, cmd_colour, cmd_mode} = c;
    screen_done = done;
    old_screen_colour = old;
    screen_x = 8'($urandom);
    screen_y = 8'($urandom);
    #1;
    if (model_ok) compare();
    @(posedge clock);
    model_update();
  endtask

  task automatic idle(input int n, input bit done);
    for (int i = 0; i < n; i++) step(0, 0, rnd_cmd(), done, 3'($urandom));
  endtask

  initial begin
    cmd_t c;
    step(1, 0, '0, 0, '0);
    step(1, 0, '0, 0, '0);
    idle(2, 0);

    // Single overwrite command into an idle queue, done after a few busy cycles.
    c = '{x: 8'd10, y: 8'd20, xr: 8'd5, yr: 8'd3, col: 3'b101, mode: 2'd0};
    step(0, 1, c, 0, 3'b010);
    idle(5, 0);
    step(0, 0, rnd_cmd(), 1, 3'b000);
    idle(4, 0);

    // XOR then OR with colour 110 against old 011.
    c = '{x: 8'd1, y: 8'd2, xr: 8'd3, yr: 8'd4, col: 3'b110, mode: 2'd1};
    step(0, 1, c, 0, 3'b011);
    c.mode = 2'd2;
    step(0, 1, c, 0, 3'b011);
    for (int i = 0; i < 6; i++) step(0, 0, rnd_cmd(), 0, 3'b011);
    step(0, 0, rnd_cmd(), 1, 3'b011);
    for (int i = 0; i < 8; i++) step(0, 0, rnd_cmd(), 0, 3'b011);
    step(0, 0, rnd_cmd(), 1, 3'b011);
    idle(4, 0);

    // Fill the queue with done held low: back-pressure, then watchdog aborts.
    for (int i = 0; i < 8; i++) step(0, 1, rnd_cmd(), 0, 3'($urandom));
    idle(60, 0);

    // Reset in the middle of a fill with commands queued.
    for (int i = 0; i < 4; i++) step(0, 1, rnd_cmd(), 0, 3'($urandom));
    idle(3, 0);
    step(1, 0, rnd_cmd(), 0, 3'($urandom));
    idle(2, 0);

    // Randomized phases with varying done probability.
    for (int ph = 0; ph < 12; ph++) begin
      int pv;
      int pd;
      pv = (ph % 3 == 0) ? 80 : 30;
      pd = (ph % 4 == 1) ? 0 : ((ph % 2 == 0) ? 25 : 8);
      for (int i = 0; i < 220; i++) begin
        bit rst;
        rst = ($urandom_range(0, 399) == 0);
        step(rst, ($urandom_range(0, 99) < pv), rnd_cmd(),
             ($urandom_range(0, 99) < pd), 3'($urandom));
      end
    end
    idle(80, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
